// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encodings and
// line/parity level constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } tx_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable baud down-counter: after a load of div the tick is asserted in
// the (div+1)-th clock, i.e. the last clock of the bit period.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= i_div;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, one or two stop bits; format and divisor latched per frame.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  output logic                  o_ready,
  input  logic                  i_par_en,
  input  logic                  i_par_odd,
  input  logic                  i_two_stop,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic                  load;
  logic [DIV_WIDTH-1:0]  load_div;

  // The acceptance edge must load the live divisor, since div_q is only
  // being written on that same edge.
  assign load_div = (state_q == IDLE) ? i_baud_div : div_q;

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (load),
    .i_div   (load_div),
    .o_tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    div_d      = div_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (i_data_valid) begin
          state_d    = START;
          shreg_d    = i_data;
          par_en_d   = i_par_en;
          par_bit_d  = (^i_data) ^ (i_par_odd == PAR_ODD);
          two_stop_d = i_two_stop;
          div_d      = i_baud_div;
          idx_d      = '0;
          stop_d     = 1'b0;
          tx_d       = LINE_START;
          load       = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          load    = 1'b1;
        end
      end

      DATA: begin
        if (tick) begin
          load = 1'b1;
          if (idx_q == LAST_IDX) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = STOP;
              tx_d    = LINE_IDLE;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
          load    = 1'b1;
        end
      end

      STOP: begin
        tx_d = LINE_IDLE;
        if (tick) begin
          if (two_stop_q && !stop_q) begin
            stop_d = 1'b1;
            load   = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      div_q      <= '0;
      tx_q       <= LINE_IDLE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that serialises one data word per frame, in this order: start bit, DATA_WIDTH data bits (LSB first), optional parity, then 1 or 2 stop bits.
- Built-in baud prescaler: bit period = i_baud_div+1 clocks.
- Valid/ready handshake toward the upstream producer.
- Per-frame configuration latched at acceptance.
- Drives the serial line directly. Successor to the current fixed-format TX datapath.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
DIV_WIDTH, 16, width of the baud divisor input.

Ports:
i_clk  input  1  system clock, all logic on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_data  input  DATA_WIDTH  word to transmit; sampled on acceptance.
i_data_valid  input  1  producer has a word.
o_ready  output  1  block can accept a word this cycle.
i_par_en  input  1  1 = parity bit inserted.
i_par_odd  input  1  0 = even parity, 1 = odd parity.
i_two_stop  input  1  0 = one stop bit, 1 = two stop bits.
i_baud_div  input  DIV_WIDTH  clocks per bit minus 1.
o_tx  output  1  serial line, idle high, registered.
o_busy  output  1  frame in progress (state != IDLE).
o_done  output  1  one-cycle pulse on return to IDLE after a frame.

Behaviour:
- Reset (async assert, sync release):
  - o_tx=1, o_busy=0, o_ready=1, o_done=0.
  - State IDLE; all counters and the shift register 0.
- States, 3-bit encoding: IDLE=000, START=001, DATA=010, PARITY=011, STOP=100. Unused codes go to IDLE with o_tx=1.
- o_ready = (state==IDLE). Acceptance = i_data_valid && o_ready at a rising edge.
- On acceptance:
  - Latch i_data, i_par_en, i_par_odd, i_two_stop and i_baud_div.
  - Changes on these inputs after acceptance have no effect on the current frame.
  - On the same edge: state=START, o_tx=0, o_busy=1.
- Bit timing:
  - The baud counter loads the latched divisor at each bit start and decrements to 0.
  - Each bit lasts exactly div+1 clocks. div=0 gives 1 clock per bit.
- Transitions, each taken at the end of the bit:
  - START -> DATA.
  - DATA: bit index runs 0..DATA_WIDTH-1, with o_tx = data[index]. After the last bit: -> PARITY if par_en, else -> STOP.
  - PARITY: o_tx = ^data XOR par_odd. Then -> STOP.
  - STOP: o_tx=1. Lasts 1 bit, or 2 bits if two_stop. Then -> IDLE.
- o_tx is registered and changes on the same edge as the state.
- Frame length = (1 + DATA_WIDTH + par_en + 1 + two_stop) * (div+1) clocks, counted from the acceptance edge to the IDLE-entry edge.
- On IDLE entry after a frame: o_done=1 for exactly one cycle, o_busy=0, o_ready=1.
- Back-to-back frames:
  - If i_data_valid is high during the o_done cycle, the next word is accepted at the end of that cycle.
  - The line is therefore high for stop bits plus exactly 1 clock between frames. No further gap is inserted.
- i_data_valid while busy: ignored, nothing captured. The producer holds the word until o_ready.
- Reset mid-frame: o_tx goes high immediately (async). The frame is abandoned, no o_done pulse, and state is IDLE after release.
- Bit-index and stop counters are sized $clog2(DATA_WIDTH) and 1 bit respectively. No wrap beyond the frame.

Decomposition:
- Shared package uart_pkg:
  - State encodings IDLE..STOP (3'b000..3'b100).
  - Parity constants PAR_EVEN=0, PAR_ODD=1.
  - Line level constants LINE_IDLE=1, LINE_START=0.
- One sub-module uart_baud_tick:
  - Loadable down-counter with DIV_WIDTH bits.
  - Inputs: i_clk, i_rst_n, i_load, i_div.
  - Output o_tick, asserted in the last clock of each bit period.
- The FSM, shift register and output mux stay in uart_tx_frame.

Test Plan:
- Even parity, one stop: DATA_WIDTH=8, div=3, par_en=1, par_odd=0, two_stop=0, send 0xA5.
  - o_tx per 4-clock bit: 0,1,0,1,0,0,1,0,1,0,1.
  - o_done 44 clocks after acceptance.
- Odd parity, two stops: same setup with par_odd=1, two_stop=1, send 0x00.
  - Parity bit = 1, then two high stop bits.
  - Frame 48 clocks; o_ready low for all 48.
- No parity, minimum divisor: par_en=0, div=0, send 0xFF.
  - 10-clock frame: 0, eight 1s, 1.
  - o_done on clock 10.
- Back-to-back: hold valid high with 0x12 then 0x34, div=1, no parity.
  - Second start bit begins exactly 1 clock after the first frame's stop bit ends.
  - Exactly 2 o_done pulses.
- Mid-frame changes: change i_data, i_baud_div and i_par_en during the DATA state.
  - Frame bits and timing unchanged from the latched values.
  - i_data_valid pulses while busy produce no extra frame.
- Reset mid-frame: assert i_rst_n=0 during bit 3 of the data bits.
  - o_tx=1 and o_busy=0 asynchronously, no o_done.
  - After release, a new 0x5A frame transmits correctly.
